muller_bank_sync: RTL
=====================

// Module: muller_bank_sync
// PURPOSE
//  Clocked, parametrised successor of the 2-input Muller C-element: a bank of W independent N-input C-elements.
//  - Each channel output takes its inputs' common value when all N inputs agree, and holds otherwise.
//  - Adds bank completion detection, a 4-phase cycle counter and a per-channel disagreement watchdog.
//  - Sits between synchronous control logic and handshake-style req/ack fabrics in the FPGA/emulation flow.
// PARAMETERS
//  W    4   number of channels (>=1)
//  N    2   inputs per channel (>=2)
//  INIT 0   W-bit reset value of z, bit c = channel c
//  TMO  16  disagreement cycles before err[c] sets (1..2^16-1)
//  CW   8   width of cycle counter cnt (>=1)
// PORTS
//  clk      in   1      rising-edge clock
//  rst      in   1      synchronous reset, active-high
//  in       in   W*N    channel c inputs = in[c*N +: N]
//  clr_err  in   1      clears all err bits (synchronous)
//  z        out  W      C-element outputs
//  z_rise   out  W      1-cycle pulse: z[c] went 0->1 this edge
//  z_fall   out  W      1-cycle pulse: z[c] went 1->0 this edge
//  all_set  out  1      z == all ones (registered)
//  all_clr  out  1      z == all zeros (registered)
//  cnt      out  CW     completed bank 4-phase cycles, wraps mod 2^CW
//  err      out  W      sticky watchdog flag per channel
// BEHAVIOUR
//  - Reset: with rst=1 at a clk edge, all of the following load together:
//    - z=INIT, z_rise=z_fall=0, cnt=0, err=0, watchdog counters=0, FSM=WAIT_SET.
//    - all_set / all_clr take the values computed from INIT.
//    - Reset mid-handshake discards all progress.
//  - Per channel c, each edge:
//    - all N inputs = 1 -> z[c]<=1; all = 0 -> z[c]<=0; mixed -> z[c] holds.
//    - Latency: 1 clk from inputs agreeing to z (3 clk with MULLER_SYNC_EN).
//  - z_rise / z_fall: registered with z in the same edge; high exactly one cycle per transition.
//  - all_set / all_clr: registered with z; they reflect the new z, not the old one.
//  - Cycle FSM, two states, decided on next-state z:
//    - WAIT_SET: next z all ones -> WAIT_CLR.
//    - WAIT_CLR: next z all zeros -> WAIT_SET and cnt<=cnt+1 in the same edge.
//    - cnt wraps 2^CW-1 -> 0 with no flag.
//    - W=1: a full 0->1->0 sequence counts one cycle.
//  - Watchdog per channel, 16-bit counter wd[c]:
//    - Inputs mixed -> wd[c] increments, saturating at TMO.
//    - Inputs agree -> wd[c]<=0.
//    - err[c]<=1 on the edge where wd[c] reaches TMO, i.e. the TMO-th consecutive mixed cycle.
//  - err is sticky: clr_err=1 clears all bits.
//    - If clr_err and a new set of err[c] occur in the same cycle, set wins.
//    - The watchdog does not affect z.
//  - No combinational path from any input to any output.
// CONFIGURATION
//  MULLER_SYNC_EN defined:
//    - every in bit passes through a 2-flop synchroniser before the C-element logic (inputs may be asynchronous).
//    - Synchroniser flops reset to 0.
//    - Latency: +2 clk on z, pulses, all_set / all_clr, cnt and watchdog.
//  MULLER_SYNC_EN undefined:
//    - in is used directly and must be synchronous to clk.
//    - Latency: 1 clk.
// TESTING  (W=4 N=3 INIT=0 TMO=8 CW=8, MULLER_SYNC_EN off unless noted)
//  1. rst 1 cycle, in=0 -> z=0, all_clr=1, all_set=0, cnt=0, err=0.
//  2. ch0 in=3'b011 held 5 cycles, then 3'b111 -> z[0] stays 0 for 5 cycles.
//     -> z[0]=1 and z_rise[0]=1 one cycle after 3'b111, and z_rise[0]=0 the next cycle.
//  3. All channels 3'b111 then all 3'b000 -> all_set=1, then all_clr=1, and cnt 0->1 on the all-zero edge.
//     - Repeat 256 times -> cnt wraps to 0.
//  4. ch2 in=3'b101 for 8 cycles -> err[2]=1 on the 8th edge, err[2] stays 1 after inputs agree.
//     - clr_err during the 8th edge -> err[2]=1 still.
//     - clr_err later -> err[2]=0.
//  5. rst asserted while FSM is in WAIT_CLR with z=4'b1111 -> z=0, cnt=0, FSM=WAIT_SET.
//     - A following all-zero phase does not increment cnt.
//  6. MULLER_SYNC_EN on: in=all ones at cycle 0 -> z=4'hF at cycle 3, all_set=1 at cycle 3.

Source files
------------

// File: rtl/muller_bank_sync.sv
// Bank of W clocked N-input Muller C-elements with completion flags, 4-phase cycle counter and
// per-channel disagreement watchdog. Latency 1 clk (3 clk with MULLER_SYNC_EN); no backpressure.
module muller_bank_sync #(
  parameter int            W    = 4,
  parameter int            N    = 2,
  parameter logic [W-1:0]  INIT = '0,
  parameter int            TMO  = 16,
  parameter int            CW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W*N-1:0]  in,
  input  logic            clr_err,
  output logic [W-1:0]    z,
  output logic [W-1:0]    z_rise,
  output logic [W-1:0]    z_fall,
  output logic            all_set,
  output logic            all_clr,
  output logic [CW-1:0]   cnt,
  output logic [W-1:0]    err
);

  localparam logic [15:0] TMO_W  = 16'(TMO);
  localparam logic [15:0] TMO_M1 = 16'(TMO - 1);

  typedef enum logic {WAIT_SET = 1'b0, WAIT_CLR = 1'b1} state_t;

  logic [W*N-1:0] in_s;

`ifdef MULLER_SYNC_EN
  // Two-flop synchroniser per input bit; inputs may be asynchronous to clk.
  logic [W*N-1:0] sync1, sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
    end
  end

  assign in_s = sync2;
`else
  assign in_s = in;
`endif

  logic [W-1:0] ch_one, ch_zero, ch_mix, z_nxt, err_set;
  logic [15:0]  wd [W];
  state_t       state, state_nxt;
  logic         cnt_inc;

  always_comb begin
    ch_one  = '0;
    ch_zero = '0;
    ch_mix  = '0;
    err_set = '0;
    for (int c = 0; c < W; c++) begin
      ch_one[c]  = &in_s[c*N +: N];
      ch_zero[c] = ~|in_s[c*N +: N];
      ch_mix[c]  = ~(ch_one[c] | ch_zero[c]);
      err_set[c] = ch_mix[c] && (wd[c] == TMO_M1);
    end
    z_nxt = (z & ~ch_zero) | ch_one;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z       <= INIT;
      z_rise  <= '0;
      z_fall  <= '0;
      all_set <= &INIT;
      all_clr <= ~|INIT;
    end else begin
      z       <= z_nxt;
      z_rise  <= z_nxt & ~z;
      z_fall  <= ~z_nxt & z;
      all_set <= &z_nxt;
      all_clr <= ~|z_nxt;
    end
  end

  // Cycle FSM looks at next-state z so the count lands on the same edge as the all-zero z.
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_SET;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_SET: if (&z_nxt)  state_nxt = WAIT_CLR;
      WAIT_CLR: if (~|z_nxt) state_nxt = WAIT_SET;
      default:               state_nxt = WAIT_SET;
    endcase
  end

  always_comb begin
    cnt_inc = (state == WAIT_CLR) && (~|z_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst)          cnt <= '0;
    else if (cnt_inc) cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < W; c++) wd[c] <= '0;
      err <= '0;
    end else begin
      for (int c = 0; c < W; c++) begin
        if (!ch_mix[c])          wd[c] <= '0;
        else if (wd[c] != TMO_W) wd[c] <= wd[c] + 16'd1;
      end
      // A fresh set beats a simultaneous clear.
      err <= (err & ~{W{clr_err}}) | err_set;
    end
  end

endmodule
